// File: rtl/param_loader_pkg.sv
// -----------------------------------------------------------------------------
// param_loader_pkg
// Shared definitions for the parameter loader:
//   - state_e           : loader FSM states
//   - IDX_*             : word index of each DIC parameter in the parameter BRAM
//   - DEFAULT_*         : default word count and required-field mask
// -----------------------------------------------------------------------------
package param_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Word layout of the parameter block written by the PS.
  localparam int unsigned IDX_HEIGHT       = 0;
  localparam int unsigned IDX_WIDTH        = 1;
  localparam int unsigned IDX_NUM_PXL      = 2;
  localparam int unsigned IDX_NUM_BITS     = 3;
  localparam int unsigned IDX_NUM_SUBSETS  = 4;
  localparam int unsigned IDX_OPT_METHOD   = 5;
  localparam int unsigned IDX_CORR_ROUTINE = 6;

  localparam int unsigned DEFAULT_NUM_PARAMS = 7;

  // Only the pixel count is mandatory by default: a zero there would make
  // every downstream block divide or loop over nothing.
  localparam logic [DEFAULT_NUM_PARAMS-1:0] DEFAULT_REQ_MASK =
    DEFAULT_NUM_PARAMS'(1) << IDX_NUM_PXL;

endpackage

// File: rtl/param_rise_detect.sv
// -----------------------------------------------------------------------------
// param_rise_detect
// One-bit synchronous rising-edge detector.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (clears the history register)
//   d_i    in  level input
//   rise_o out high for the cycle where d_i is 1 and was 0 on the last edge
// -----------------------------------------------------------------------------
module param_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/param_loader.sv
// -----------------------------------------------------------------------------
// param_loader
// Re-triggerable parameter fetcher. On a rising edge of start it reads
// NUM_PARAMS consecutive words from the parameter BRAM (read latency RD_LAT)
// into a shadow bank, checks that every word flagged in REQ_MASK is nonzero,
// and then either commits the whole bank to params in one edge (done) or
// keeps the previous commit and flags err.
// Ports:
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   start      in  load request (rising-edge triggered)
//   bram_en    out BRAM enable, high while a word is being read
//   bram_we    out BRAM write enable, always 0
//   bram_addr  out BRAM byte address, BASE_ADDR + idx*ADDR_STRIDE
//   bram_dout  in  BRAM read data
//   params     out committed words, word i at [i*DATA_W +: DATA_W]
//   busy       out high in ISSUE, WAIT and CHECK
//   done       out committed set is valid
//   err        out last load failed the required-field check
// -----------------------------------------------------------------------------
module param_loader
  import param_loader_pkg::*;
#(
  parameter int unsigned             NUM_PARAMS  = DEFAULT_NUM_PARAMS,
  parameter int unsigned             DATA_W      = 32,
  parameter int unsigned             ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR   = '0,
  parameter int unsigned             ADDR_STRIDE = 4,
  parameter int unsigned             RD_LAT      = 2,
  parameter logic [NUM_PARAMS-1:0]   REQ_MASK    = NUM_PARAMS'(DEFAULT_REQ_MASK)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         bram_en,
  output logic [3:0]                   bram_we,
  output logic [ADDR_W-1:0]            bram_addr,
  input  logic [DATA_W-1:0]            bram_dout,
  output logic [NUM_PARAMS*DATA_W-1:0] params,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PARAMS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               trig;
  logic               capture;
  logic               commit;
  logic               mask_ok;
  logic [NUM_PARAMS-1:0] req_ok;

  logic [DATA_W-1:0]  shadow_q [NUM_PARAMS];
  logic [DATA_W-1:0]  params_q [NUM_PARAMS];
  logic [ADDR_W-1:0]  addr_off;

  param_rise_detect u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (start),
    .rise_o (trig)
  );

  // ---------------------------------------------------------------------------
  // Per-word shadow capture, commit and required-field check
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_q[gi] <= '0;
        end else if (capture && (idx_q == IDX_W'(gi))) begin
          shadow_q[gi] <= bram_dout;
        end
      end

      // params only moves on the single commit edge, so it never mixes
      // words from two different loads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          params_q[gi] <= '0;
        end else if (commit) begin
          params_q[gi] <= shadow_q[gi];
        end
      end

      assign req_ok[gi] = ~REQ_MASK[gi] | (|shadow_q[gi]);
      assign params[gi*DATA_W +: DATA_W] = params_q[gi];
    end
  endgenerate

  assign mask_ok = &req_ok;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    capture = 1'b0;
    commit  = 1'b0;

    case (state_q)
      // Triggers only act when not busy; a trigger during a load is dropped.
      IDLE, DONE, ERR: begin
        if (trig) begin
          state_d = ISSUE;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(RD_LAT - 1);
      end

      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CHECK: begin
        if (mask_ok) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          done_d  = 1'b0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Address is derived from idx, so it is held through ISSUE and WAIT and
  // returns to BASE_ADDR after reset. Multiplication wraps at ADDR_W bits.
  assign addr_off  = ADDR_W'(idx_q) * ADDR_W'(ADDR_STRIDE);
  assign bram_addr = BASE_ADDR + addr_off;
  assign bram_en   = (state_q == ISSUE) || (state_q == WAIT);
  assign bram_we   = 4'b0000;
  assign busy      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_param_loader.sv
module tb_param_loader;

  typedef struct {
    int           cyc;
    logic         done;
    logic         err;
    logic [223:0] params;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1: default configuration ----------------
  logic         start1 = 1'b0;
  logic         en1, busy1, done1, err1;
  logic [3:0]   we1;
  logic [31:0]  addr1, dout1;
  logic [223:0] params1;
  logic [31:0]  mem1 [7];
  logic [31:0]  pipe1_s0, pipe1_s1;

  param_loader dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_dout(dout1),
    .params(params1), .busy(busy1), .done(done1), .err(err1)
  );

  // Two-stage BRAM read model (RD_LAT=2)
  always @(posedge clk) begin
    pipe1_s0 <= (addr1[31:2] < 30'd7) ? mem1[addr1[4:2]] : 32'hDEAD_BEEF;
    pipe1_s1 <= pipe1_s0;
  end
  assign dout1 = pipe1_s1;

  // ---------------- DUT 2: swept configuration ----------------
  logic         start2 = 1'b0;
  logic         en2, busy2, done2, err2;
  logic [3:0]   we2;
  logic [31:0]  addr2, dout2;
  logic [95:0]  params2;
  logic [31:0]  mem2 [3];
  logic [31:0]  pipe2;
  logic [31:0]  off2;

  param_loader #(
    .NUM_PARAMS(3), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h100),
    .ADDR_STRIDE(8), .RD_LAT(1), .REQ_MASK(3'b001)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .bram_en(en2), .bram_we(we2), .bram_addr(addr2), .bram_dout(dout2),
    .params(params2), .busy(busy2), .done(done2), .err(err2)
  );

  assign off2 = addr2 - 32'h100;
  always @(posedge clk) begin
    pipe2 <= (off2[31:3] < 29'd3) ? mem2[off2[4:3]] : 32'hDEAD_BEEF;
  end
  assign dout2 = pipe2;

  // ---------------- scoreboard ----------------
  exp_t exp1_q[$];
  exp_t exp2_q[$];
  int   events1 = 0;
  int   events2 = 0;
  logic [31:0] alog1[$];
  int          hlog1[$];
  logic [31:0] alog2[$];
  int          hlog2[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor DUT1: a rising done or err is the decision output.
  initial begin : mon1
    logic dp, ep;
    exp_t e;
    dp = 1'b0; ep = 1'b0;
    forever begin
      @(negedge clk);
      if ((done1 && !dp) || (err1 && !ep)) begin
        events1++;
        if (exp1_q.size() == 0) begin
          chk("dut1_unexpected_decision", 1, 0);
        end else begin
          e = exp1_q.pop_front();
          chk("dut1_decision_cycle", 256'(cyc), 256'(e.cyc));
          chk("dut1_done", 256'(done1), 256'(e.done));
          chk("dut1_err", 256'(err1), 256'(e.err));
          chk("dut1_busy_low", 256'(busy1), 0);
          chk("dut1_params", 256'(params1), 256'(e.params));
        end
      end
      dp = done1; ep = err1;
    end
  end

  initial begin : mon2
    logic dp, ep;
    exp_t e;
    dp = 1'b0; ep = 1'b0;
    forever begin
      @(negedge clk);
      if ((done2 && !dp) || (err2 && !ep)) begin
        events2++;
        if (exp2_q.size() == 0) begin
          chk("dut2_unexpected_decision", 1, 0);
        end else begin
          e = exp2_q.pop_front();
          chk("dut2_decision_cycle", 256'(cyc), 256'(e.cyc));
          chk("dut2_done", 256'(done2), 256'(e.done));
          chk("dut2_err", 256'(err2), 256'(e.err));
          chk("dut2_params", 256'(params2), 256'(e.params));
        end
      end
      dp = done2; ep = err2;
    end
  end

  // Address loggers: one entry per distinct enabled address, with hold length.
  initial begin : alog
    logic        en1p, en2p;
    logic [31:0] a1p, a2p;
    en1p = 1'b0; en2p = 1'b0; a1p = '0; a2p = '0;
    forever begin
      @(negedge clk);
      if (en1) begin
        if (!en1p || addr1 != a1p) begin
          alog1.push_back(addr1); hlog1.push_back(1);
        end else begin
          hlog1[hlog1.size()-1] = hlog1[hlog1.size()-1] + 1;
        end
      end
      if (en2) begin
        if (!en2p || addr2 != a2p) begin
          alog2.push_back(addr2); hlog2.push_back(1);
        end else begin
          hlog2[hlog2.size()-1] = hlog2[hlog2.size()-1] + 1;
        end
      end
      en1p = en1; a1p = addr1; en2p = en2; a2p = addr2;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse1(output int e0);
    @(negedge clk); start1 = 1'b1; e0 = cyc + 1;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic pulse2(output int e0);
    @(negedge clk); start2 = 1'b1; e0 = cyc + 1;
    @(negedge clk); start2 = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp1_q.size() != 0 || exp2_q.size() != 0) && n < max_cycles) begin
      @(negedge clk); n++;
    end
    chk("scoreboard_drained", 256'(exp1_q.size() + exp2_q.size()), 0);
  endtask

  task automatic push1(input int c, input logic d, input logic e, input logic [223:0] p);
    exp_t x;
    x.cyc = c; x.done = d; x.err = e; x.params = p;
    exp1_q.push_back(x);
  endtask

  task automatic push2(input int c, input logic d, input logic e, input logic [223:0] p);
    exp_t x;
    x.cyc = c; x.done = d; x.err = e; x.params = p;
    exp2_q.push_back(x);
  endtask

  task automatic check_alog1(input int n, input int hold);
    chk("dut1_addr_count", 256'(alog1.size()), 256'(n));
    for (int i = 0; i < alog1.size() && i < n; i++) begin
      chk($sformatf("dut1_addr%0d", i), 256'(alog1[i]), 256'(i * 4));
      chk($sformatf("dut1_hold%0d", i), 256'(hlog1[i]), 256'(hold));
    end
  endtask

  // ---------------- main sequence ----------------
  localparam logic [223:0] P_BASIC  = {32'd2, 32'd1, 32'd25, 32'd8, 32'd307200, 32'd640, 32'd480};
  localparam logic [223:0] P_RELOAD = {32'd2, 32'd1, 32'd25, 32'd8, 32'd307200, 32'd640, 32'd1024};
  localparam logic [223:0] P_SWEEP  = {128'd0, 32'd7, 32'd6, 32'd5};

  initial begin : stim
    int e0;
    int ev0;
    mem1[0] = 32'd480; mem1[1] = 32'd640; mem1[2] = 32'd307200; mem1[3] = 32'd8;
    mem1[4] = 32'd25;  mem1[5] = 32'd1;   mem1[6] = 32'd2;
    mem2[0] = 32'd5;   mem2[1] = 32'd6;   mem2[2] = 32'd7;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy1), 0);
    chk("rst_done", 256'(done1), 0);
    chk("rst_err", 256'(err1), 0);
    chk("rst_bram_en", 256'(en1), 0);
    chk("rst_bram_addr", 256'(addr1), 0);
    chk("rst_params", 256'(params1), 0);
    chk("rst_bram_we", 256'(we1), 0);
    chk("rst_dut2_bram_addr", 256'(addr2), 256'(32'h100));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load
    alog1.delete(); hlog1.delete();
    pulse1(e0);
    push1(e0 + 22, 1'b1, 1'b0, P_BASIC);
    chk("basic_busy_after_trigger", 256'(busy1), 1);
    drain(60);
    check_alog1(7, 3);
    repeat (3) @(negedge clk);

    // Validation fail: previous commit retained
    mem1[2] = 32'd0;
    pulse1(e0);
    push1(e0 + 22, 1'b0, 1'b1, P_BASIC);
    chk("fail_done_cleared", 256'(done1), 0);
    drain(60);
    mem1[2] = 32'd307200;
    repeat (3) @(negedge clk);

    // Level start: one load only
    ev0 = events1;
    @(negedge clk); start1 = 1'b1; e0 = cyc + 1;
    push1(e0 + 22, 1'b1, 1'b0, P_BASIC);
    repeat (100) @(negedge clk);
    chk("level_one_load", 256'(events1 - ev0), 1);
    chk("level_queue_empty", 256'(exp1_q.size()), 0);

    // Drop and re-raise with new word0
    mem1[0] = 32'd1024;
    start1 = 1'b0;
    @(negedge clk); start1 = 1'b1; e0 = cyc + 1;
    push1(e0 + 22, 1'b1, 1'b0, P_RELOAD);
    @(negedge clk);
    chk("reload_done_dropped", 256'(done1), 0);
    drain(60);
    start1 = 1'b0;
    repeat (3) @(negedge clk);

    // Start while busy is ignored
    ev0 = events1;
    alog1.delete(); hlog1.delete();
    pulse1(e0);
    push1(e0 + 22, 1'b1, 1'b0, P_RELOAD);
    while (cyc < e0 + 4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    drain(60);
    repeat (30) @(negedge clk);
    chk("busy_trigger_one_decision", 256'(events1 - ev0), 1);
    check_alog1(7, 3);

    // Reset mid-load
    pulse1(e0);
    while (cyc < e0 + 9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 256'(busy1), 0);
    chk("midrst_done", 256'(done1), 0);
    chk("midrst_err", 256'(err1), 0);
    chk("midrst_params", 256'(params1), 0);
    chk("midrst_bram_en", 256'(en1), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    alog1.delete(); hlog1.delete();
    pulse1(e0);
    push1(e0 + 22, 1'b1, 1'b0, P_RELOAD);
    drain(60);
    check_alog1(7, 3);

    // Parameter sweep on DUT2
    alog2.delete(); hlog2.delete();
    pulse2(e0);
    push2(e0 + 7, 1'b1, 1'b0, P_SWEEP);
    drain(30);
    chk("sweep_addr_count", 256'(alog2.size()), 3);
    for (int i = 0; i < alog2.size() && i < 3; i++) begin
      chk($sformatf("sweep_addr%0d", i), 256'(alog2[i]), 256'(32'h100 + i * 8));
      chk($sformatf("sweep_hold%0d", i), 256'(hlog2[i]), 2);
    end
    mem2[0] = 32'd0;
    pulse2(e0);
    push2(e0 + 7, 1'b0, 1'b1, P_SWEEP);
    drain(30);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
